// File: rtl/ram_1port_be.sv
// ram_1port_be
//   Single-port RAM with byte-write enables, a 1..3 cycle read pipeline,
//   selectable read-during-write behaviour and a clear engine that zeroes
//   every word after reset or when i_Clear is pulsed.
//
//   Optional feature macro: RAM_PARITY_EN
//     defined   : one even-parity bit stored per byte, checked on read
//     undefined : no parity storage, o_Parity_Err is constant 0
//
// Ports
//   i_Clk        clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_Addr       shared read/write word address
//   i_Wr_DV      write strobe
//   i_Wr_Data    write data
//   i_Wr_BE      byte enables, bit n gates i_Wr_Data[8n+7:8n]
//   i_Rd_En      read request
//   i_Clear      pulse: restart the clear engine
//   o_Rd_DV      read data valid pulse, RD_LATENCY cycles after acceptance
//   o_Rd_Data    read data, held between o_Rd_DV pulses
//   o_Busy       clear engine running, user accesses ignored
//   o_Parity_Err parity mismatch qualified by o_Rd_DV
module ram_1port_be #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic [AW-1:0]      i_Addr,
    input  logic               i_Wr_DV,
    input  logic [WIDTH-1:0]   i_Wr_Data,
    input  logic [WIDTH/8-1:0] i_Wr_BE,
    input  logic               i_Rd_En,
    input  logic               i_Clear,
    output logic               o_Rd_DV,
    output logic [WIDTH-1:0]   o_Rd_Data,
    output logic               o_Busy,
    output logic               o_Parity_Err
);

    localparam int NB = WIDTH / 8;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = WIDTH + NB;
`else
    localparam int MEM_W = WIDTH;
`endif
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    // Stored word layout: {parity[NB-1:0], data[WIDTH-1:0]} (parity only when enabled)
    logic [MEM_W-1:0] mem [DEPTH];

    state_t           state_q;
    logic [AW-1:0]    clr_cnt_q;
    logic             busy_q;

    logic             idle;
    logic             addr_ok;
    logic             rd_accept_d;
    logic [MEM_W-1:0] wr_word_d;
    logic [MEM_W-1:0] rd_raw_d;
    logic [MEM_W-1:0] rd_word_d;
    logic             perr_d;

    logic             mem_we_d;
    logic [AW-1:0]    mem_addr_d;
    logic [NB-1:0]    mem_be_d;
    logic [MEM_W-1:0] mem_wdata_d;

    logic [RD_LATENCY-1:0] vld_p_q;
    logic [RD_LATENCY-1:0] perr_p_q;
    logic [WIDTH-1:0]      data_p_q [RD_LATENCY];

    // Builds the stored word; each parity bit makes its byte's bit count even.
    function automatic logic [MEM_W-1:0] gen_word(input logic [WIDTH-1:0] d);
        logic [MEM_W-1:0] w;
        w = '0;
        w[WIDTH-1:0] = d;
`ifdef RAM_PARITY_EN
        for (int n = 0; n < NB; n++) begin
            w[WIDTH+n] = ^d[8*n +: 8];
        end
`endif
        return w;
    endfunction

    function automatic logic chk_word(input logic [MEM_W-1:0] w);
        logic err;
        err = 1'b0;
`ifdef RAM_PARITY_EN
        for (int n = 0; n < NB; n++) begin
            err = err | (^{w[WIDTH+n], w[8*n +: 8]});
        end
`else
        err = ^w & 1'b0;
`endif
        return err;
    endfunction

    assign idle    = (state_q == ST_IDLE);
    // Only matters for non-power-of-2 DEPTH, where the top addresses are holes.
    assign addr_ok = (32'(i_Addr) < 32'(DEPTH));

    always_comb begin
        wr_word_d   = gen_word(i_Wr_Data);
        mem_we_d    = 1'b0;
        mem_addr_d  = i_Addr;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        if (!idle) begin
            // Clear engine owns the port; all-zero data has parity 0 as well.
            mem_we_d   = 1'b1;
            mem_addr_d = clr_cnt_q;
            mem_be_d   = '1;
        end else if (i_Wr_DV && addr_ok) begin
            mem_we_d    = 1'b1;
            mem_be_d    = i_Wr_BE;
            mem_wdata_d = wr_word_d;
        end
    end

    always_comb begin
        rd_accept_d = idle && i_Rd_En;
        rd_raw_d    = addr_ok ? mem[i_Addr] : '0;
        rd_word_d   = rd_raw_d;
        if ((RDW_MODE == 1) && i_Wr_DV && addr_ok) begin
            for (int n = 0; n < NB; n++) begin
                if (i_Wr_BE[n]) begin
                    rd_word_d[8*n +: 8] = wr_word_d[8*n +: 8];
`ifdef RAM_PARITY_EN
                    rd_word_d[WIDTH+n] = wr_word_d[WIDTH+n];
`endif
                end
            end
        end
        perr_d = chk_word(rd_word_d);
    end

    // Array write port: no reset so the array maps onto block RAM.
    always_ff @(posedge i_Clk) begin
        if (mem_we_d) begin
            for (int n = 0; n < NB; n++) begin
                if (mem_be_d[n]) begin
                    mem[mem_addr_d][8*n +: 8] <= mem_wdata_d[8*n +: 8];
`ifdef RAM_PARITY_EN
                    mem[mem_addr_d][WIDTH+n] <= mem_wdata_d[WIDTH+n];
`endif
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_Clear) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage p0 captures at the accepting edge; later stages only load behind a
    // valid, so the last stage (the output) holds between pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vld_p_q  <= '0;
            perr_p_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_p_q[i] <= '0;
            end
        end else begin
            vld_p_q[0] <= rd_accept_d;
            if (rd_accept_d) begin
                data_p_q[0] <= rd_word_d[WIDTH-1:0];
                perr_p_q[0] <= perr_d;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p_q[i] <= vld_p_q[i-1];
                if (vld_p_q[i-1]) begin
                    data_p_q[i] <= data_p_q[i-1];
                    perr_p_q[i] <= perr_p_q[i-1];
                end
            end
        end
    end

    assign o_Rd_DV      = vld_p_q[RD_LATENCY-1];
    assign o_Rd_Data    = data_p_q[RD_LATENCY-1];
    assign o_Parity_Err = vld_p_q[RD_LATENCY-1] & perr_p_q[RD_LATENCY-1];
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_ram_1port_be.sv
`timescale 1ns/1ps
module tb_ram_1port_be;

    // Two instances share the stimulus: A = 256 words, latency 1, read-first;
    // B = 200 words, latency 3, write-first.
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic        wr_dv;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic        clr;

    logic        dv_a, busy_a, perr_a, dv_b, busy_b, perr_b;
    logic [15:0] rd_a, rd_b;

    always #5 clk = ~clk;

    ram_1port_be #(.WIDTH(16), .DEPTH(256), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Addr(addr), .i_Wr_DV(wr_dv),
        .i_Wr_Data(wr_data), .i_Wr_BE(wr_be), .i_Rd_En(rd_en), .i_Clear(clr),
        .o_Rd_DV(dv_a), .o_Rd_Data(rd_a), .o_Busy(busy_a), .o_Parity_Err(perr_a));

    ram_1port_be #(.WIDTH(16), .DEPTH(200), .RD_LATENCY(3), .RDW_MODE(1)) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Addr(addr), .i_Wr_DV(wr_dv),
        .i_Wr_Data(wr_data), .i_Wr_BE(wr_be), .i_Rd_En(rd_en), .i_Clear(clr),
        .o_Rd_DV(dv_b), .o_Rd_Data(rd_b), .o_Busy(busy_b), .o_Parity_Err(perr_b));

    typedef struct {
        logic [15:0] data;
        logic        perr;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] ref_mem [2][256];
    logic        bad_par [2][256];
    logic        m_busy [2];
    int          m_cnt [2];
    logic [15:0] hold [2];
    logic [15:0] last_pop [2];
    logic        last_perr [2];

    logic        dv_w [2];
    logic        busy_w [2];
    logic        perr_w [2];
    logic [15:0] rd_w [2];
    assign dv_w[0] = dv_a;   assign dv_w[1] = dv_b;
    assign busy_w[0] = busy_a; assign busy_w[1] = busy_b;
    assign perr_w[0] = perr_a; assign perr_w[1] = perr_b;
    assign rd_w[0] = rd_a;   assign rd_w[1] = rd_b;

    function automatic int dep(int d); return (d == 0) ? 256 : 200; endfunction
    function automatic int lat(int d); return (d == 0) ? 1 : 3; endfunction
    function automatic int rdw(int d); return (d == 0) ? 0 : 1; endfunction

    function automatic bit sb_empty(int d);
        return (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    endfunction
    function automatic int sb_front_due(int d);
        return (d == 0) ? q_a[0].due : q_b[0].due;
    endfunction
    function automatic exp_t sb_pop(int d);
        exp_t e;
        if (d == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        return e;
    endfunction

    // Reference behaviour of one clock edge for both instances.
    task automatic model_edge();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (m_busy[d]) begin
                ref_mem[d][m_cnt[d]] = 16'h0000;
                bad_par[d][m_cnt[d]] = 1'b0;
                if (m_cnt[d] == dep(d) - 1) m_busy[d] = 1'b0;
                m_cnt[d]++;
            end else begin
                exp_t        e;
                logic        inr;
                logic [15:0] old_w;
                logic [15:0] new_w;
                inr   = (int'(addr) < dep(d));
                old_w = inr ? ref_mem[d][addr] : 16'h0000;
                new_w = old_w;
                if (wr_dv && inr) begin
                    if (wr_be[0]) new_w[7:0]  = wr_data[7:0];
                    if (wr_be[1]) new_w[15:8] = wr_data[15:8];
                end
                if (rd_en) begin
                    e.data = (rdw(d) == 1) ? new_w : old_w;
                    e.perr = inr && bad_par[d][addr] && !((rdw(d) == 1) && wr_dv && wr_be[0]);
                    e.due  = cyc + lat(d) - 1;
                    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
                end
                if (wr_dv && inr) begin
                    ref_mem[d][addr] = new_w;
                    if (wr_be[0]) bad_par[d][addr] = 1'b0;
                end
                if (clr) begin
                    m_busy[d] = 1'b1;
                    m_cnt[d]  = 0;
                end
            end
        end
    endtask

    // One clock: model at the rising edge, scoreboard at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge(); else cyc++;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_w[d] !== m_busy[d]) begin
                errors++;
                $display("FAIL busy_%0d cyc %0d got %b want %b", d, cyc, busy_w[d], m_busy[d]);
            end
            if (dv_w[d] === 1'b1) begin
                if (sb_empty(d)) begin
                    checks++; errors++;
                    $display("FAIL unexpected_dv_%0d cyc %0d got data %h want no pulse", d, cyc, rd_w[d]);
                end else begin
                    exp_t e;
                    e = sb_pop(d);
                    checks++;
                    if (rd_w[d] !== e.data || cyc != e.due || perr_w[d] !== e.perr) begin
                        errors++;
                        $display("FAIL read_%0d cyc %0d got %h perr %b want %h perr %b at cyc %0d",
                                 d, cyc, rd_w[d], perr_w[d], e.data, e.perr, e.due);
                    end
                    last_pop[d]  = rd_w[d];
                    last_perr[d] = perr_w[d];
                end
            end else begin
                checks++;
                if (rd_w[d] !== hold[d] || perr_w[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_%0d cyc %0d got %h perr %b want %h perr 0", d, cyc, rd_w[d], perr_w[d], hold[d]);
                end
                if (!sb_empty(d) && sb_front_due(d) <= cyc) begin
                    exp_t e;
                    e = sb_pop(d);
                    checks++; errors++;
                    $display("FAIL missing_dv_%0d cyc %0d got no pulse want %h", d, cyc, e.data);
                end
            end
            hold[d] = rd_w[d];
        end
    endtask

    task automatic idle_inputs();
        addr = 8'h00; wr_dv = 1'b0; wr_data = 16'h0000; wr_be = 2'b00; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset(int cycles);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        q_a.delete();
        q_b.delete();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b1; m_cnt[d] = 0; hold[d] = 16'h0000;
        end
        checks++;
        if ({dv_a, dv_b, perr_a, perr_b, busy_a, busy_b} !== 6'b000011 || rd_a !== 16'h0 || rd_b !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got dv %b%b perr %b%b busy %b%b data %h %h want 000011 0000 0000",
                     dv_a, dv_b, perr_a, perr_b, busy_a, busy_b, rd_a, rd_b);
        end
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    task automatic count_busy(input bit junk, output int na, output int nb);
        na = 0; nb = 0;
        for (int c = 0; c < 300; c++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (!busy_a && !busy_b) break;
            wr_dv   = junk && busy_a && busy_b;
            rd_en   = junk && busy_a && busy_b;
            addr    = 8'($urandom_range(0, 255));
            wr_data = 16'($urandom);
            wr_be   = 2'b11;
            clr     = junk && (c == 50);
            step();
        end
        idle_inputs();
    endtask

    task automatic drain();
        idle_inputs();
        for (int c = 0; c < 10 && !(sb_empty(0) && sb_empty(1)); c++) step();
        checks++;
        if (!(sb_empty(0) && sb_empty(1))) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
            q_a.delete(); q_b.delete();
        end
    endtask

    task automatic write_word(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        addr = a; wr_dv = 1'b1; wr_data = d; wr_be = be; rd_en = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic read_word(input logic [7:0] a);
        addr = a; rd_en = 1'b1; wr_dv = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        int na, nb;
        do_reset(3);
        count_busy(1'b0, na, nb);
        checks++;
        if (na != 256 || nb != 200) begin
            errors++;
            $display("FAIL clear_after_reset got %0d/%0d busy cycles want 256/200", na, nb);
        end
        read_word(8'h00); read_word(8'h7F); read_word(8'hFF);
        drain();
        checks++;
        if (last_pop[0] !== 16'h0000 || last_pop[1] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read got %h %h want 0000 0000", last_pop[0], last_pop[1]);
        end
    endtask

    task automatic test_byte_enable();
        write_word(8'h10, 16'hABCD, 2'b11);
        write_word(8'h10, 16'h1234, 2'b10);
        read_word(8'h10);
        drain();
        checks++;
        if (last_pop[0] !== 16'h12CD || last_pop[1] !== 16'h12CD) begin
            errors++;
            $display("FAIL byte_enable got %h %h want 12cd 12cd", last_pop[0], last_pop[1]);
        end
        write_word(8'h10, 16'hFFFF, 2'b00);
        read_word(8'h10);
        drain();
        checks++;
        if (last_pop[0] !== 16'h12CD || last_pop[1] !== 16'h12CD) begin
            errors++;
            $display("FAIL be_zero got %h %h want 12cd 12cd", last_pop[0], last_pop[1]);
        end
    endtask

    task automatic test_rdw();
        write_word(8'h20, 16'h1111, 2'b11);
        addr = 8'h20; wr_dv = 1'b1; wr_data = 16'h2222; wr_be = 2'b11; rd_en = 1'b1;
        step();
        drain();
        checks++;
        if (last_pop[0] !== 16'h1111 || last_pop[1] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_same_cycle got %h %h want 1111 2222", last_pop[0], last_pop[1]);
        end
        read_word(8'h20);
        drain();
        checks++;
        if (last_pop[0] !== 16'h2222 || last_pop[1] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_after got %h %h want 2222 2222", last_pop[0], last_pop[1]);
        end
    endtask

    task automatic test_back_to_back();
        int na, nb, fa, fb;
        for (int i = 0; i < 8; i++) write_word(8'(i), 16'(i), 2'b11);
        na = 0; nb = 0; fa = -1; fb = -1;
        for (int i = 0; i < 14; i++) begin
            rd_en = (i < 8);
            addr  = 8'(i);
            step();
            if (dv_a) begin na++; if (fa < 0) fa = i; end
            if (dv_b) begin nb++; if (fb < 0) fb = i; end
        end
        drain();
        checks++;
        if (na != 8 || nb != 8 || fa != 0 || fb != 2 || last_pop[0] !== 16'd7 || last_pop[1] !== 16'd7) begin
            errors++;
            $display("FAIL back_to_back got cnt %0d/%0d first %0d/%0d last %h/%h want 8/8 0/2 0007/0007",
                     na, nb, fa, fb, last_pop[0], last_pop[1]);
        end
    endtask

    task automatic test_out_of_range();
        write_word(8'hC8, 16'h5555, 2'b11);
        read_word(8'hC8);
        drain();
        checks++;
        if (last_pop[0] !== 16'h5555 || last_pop[1] !== 16'h0000) begin
            errors++;
            $display("FAIL out_of_range got %h %h want 5555 0000", last_pop[0], last_pop[1]);
        end
    endtask

    task automatic test_clear();
        int na, nb;
        for (int i = 0; i < 4; i++) write_word(8'h30 + 8'(i), 16'hBEEF, 2'b11);
        addr = 8'h31; wr_dv = 1'b1; wr_data = 16'hBEEF; wr_be = 2'b11; clr = 1'b1;
        step();
        count_busy(1'b1, na, nb);
        checks++;
        if (na != 256 || nb != 200) begin
            errors++;
            $display("FAIL clear_request got %0d/%0d busy cycles want 256/200", na, nb);
        end
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i); rd_en = 1'b1;
            step();
        end
        drain();
        checks++;
        if (last_pop[0] !== 16'h0000 || last_pop[1] !== 16'h0000) begin
            errors++;
            $display("FAIL clear_contents got %h %h want 0000 0000", last_pop[0], last_pop[1]);
        end
        write_word(8'h40, 16'h7777, 2'b11);
        addr = 8'h40; rd_en = 1'b1; clr = 1'b1;
        step();
        idle_inputs();
        step();
        do_reset(2);
        count_busy(1'b0, na, nb);
        checks++;
        if (na != 256 || nb != 200) begin
            errors++;
            $display("FAIL reset_mid_clear got %0d/%0d busy cycles want 256/200", na, nb);
        end
    endtask

    task automatic test_parity();
        write_word(8'h05, 16'h00FF, 2'b11);
        read_word(8'h05);
        read_word(8'h06);
        drain();
        checks++;
        if (last_perr[0] !== 1'b0 || last_perr[1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean got %b %b want 0 0", last_perr[0], last_perr[1]);
        end
`ifdef RAM_PARITY_EN
        dut_a.mem[5][0] = ~dut_a.mem[5][0];
        dut_b.mem[5][0] = ~dut_b.mem[5][0];
        for (int d = 0; d < 2; d++) begin
            ref_mem[d][5] = 16'h00FE;
            bad_par[d][5] = 1'b1;
        end
        read_word(8'h05);
        drain();
        checks++;
        if (last_perr[0] !== 1'b1 || last_perr[1] !== 1'b1) begin
            errors++;
            $display("FAIL parity_flip got %b %b want 1 1", last_perr[0], last_perr[1]);
        end
        read_word(8'h06);
        drain();
        checks++;
        if (last_perr[0] !== 1'b0 || last_perr[1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_other got %b %b want 0 0", last_perr[0], last_perr[1]);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            last_pop[d] = 16'hXXXX; last_perr[d] = 1'b0;
            for (int a = 0; a < 256; a++) begin
                ref_mem[d][a] = 16'h0000; bad_par[d][a] = 1'b0;
            end
        end
        #2;
        test_reset();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_out_of_range();
        test_clear();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
